// File: rtl/set_button_conditioner_if.sv
// Signal bundle between the raw SET push-buttons and their conditioner.
// The conditioner sits on the slave side; whoever drives the pins is master.
interface set_button_conditioner_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_raw;
    logic               repeat_en;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_event;

    modport master (
        output btn_raw,
        output repeat_en,
        input  btn_level,
        input  btn_press,
        input  btn_event
    );

    modport slave (
        input  btn_raw,
        input  repeat_en,
        output btn_level,
        output btn_press,
        output btn_event
    );
endinterface

// File: rtl/set_button_conditioner.sv
// Per-channel synchronizer, debouncer and press / auto-repeat pulse generator
// for the alarm-clock SET buttons. All outputs are registered.
module set_button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    set_button_conditioner_if.slave   btn_if
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0]      DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]      DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]      PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [NUM_BTN-1:0] IDLE_LEVEL  = {NUM_BTN{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rpt_state_t;

    logic [NUM_BTN-1:0] sync1_reg;
    logic [NUM_BTN-1:0] sync2_reg;
    logic [NUM_BTN-1:0] s;
    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] event_vec;

    // Synchronizers rest at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= IDLE_LEVEL;
            sync2_reg <= IDLE_LEVEL;
        end else begin
            sync1_reg <= btn_if.btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg ^ IDLE_LEVEL;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            logic [DW-1:0] dcnt_reg;
            logic [DW-1:0] dcnt_next;
            logic          level_reg;
            logic          level_next;
            logic          press_reg;
            logic          press_next;
            logic          event_reg;
            logic          event_next;
            logic [RW-1:0] rcnt_reg;
            logic [RW-1:0] rcnt_next;
            rpt_state_t    state_reg;
            rpt_state_t    state_next;
            logic          rise;
            logic          fall;

            always_comb begin
                dcnt_next  = '0;
                level_next = level_reg;
                rise       = 1'b0;
                fall       = 1'b0;
                if (s[gi] != level_reg) begin
                    if (dcnt_reg == DCNT_LAST) begin
                        level_next = s[gi];
                        rise       = s[gi];
                        fall       = ~s[gi];
                    end else begin
                        dcnt_next = dcnt_reg + 1'b1;
                    end
                end
            end

            // A release accepted on this edge counts as released, so it
            // suppresses a repeat pulse that would otherwise fire now.
            always_comb begin
                state_next = state_reg;
                rcnt_next  = rcnt_reg;
                event_next = 1'b0;
                press_next = rise;
                case (state_reg)
                    ST_IDLE: begin
                        if (rise) begin
                            state_next = ST_HOLD;
                            rcnt_next  = '0;
                            event_next = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!level_reg || fall) begin
                            state_next = ST_IDLE;
                            rcnt_next  = '0;
                        end else if (!btn_if.repeat_en) begin
                            rcnt_next = '0;
                        end else if (rcnt_reg == DELAY_LAST) begin
                            state_next = ST_REPEAT;
                            rcnt_next  = '0;
                            event_next = 1'b1;
                        end else begin
                            rcnt_next = rcnt_reg + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        // Dropping repeat_en parks the channel until a fresh press.
                        if (!level_reg || fall || !btn_if.repeat_en) begin
                            state_next = ST_IDLE;
                            rcnt_next  = '0;
                        end else if (rcnt_reg == PERIOD_LAST) begin
                            rcnt_next  = '0;
                            event_next = 1'b1;
                        end else begin
                            rcnt_next = rcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        rcnt_next  = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dcnt_reg  <= '0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    event_reg <= 1'b0;
                    rcnt_reg  <= '0;
                    state_reg <= ST_IDLE;
                end else begin
                    dcnt_reg  <= dcnt_next;
                    level_reg <= level_next;
                    press_reg <= press_next;
                    event_reg <= event_next;
                    rcnt_reg  <= rcnt_next;
                    state_reg <= state_next;
                end
            end

            assign level_vec[gi] = level_reg;
            assign press_vec[gi] = press_reg;
            assign event_vec[gi] = event_reg;
        end
    endgenerate

    assign btn_if.btn_level = level_vec;
    assign btn_if.btn_press = press_vec;
    assign btn_if.btn_event = event_vec;

endmodule
